// File: rtl/code_mem_loader_pkg.sv
// Shared types for the code memory loader: frame FSM states, length width
// and the running checksum helper.
package code_mem_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // True in the states where a frame is in flight and bytes are consumed.
  function automatic logic frame_active(input state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
  endfunction

  // One step of the XOR payload checksum.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/code_mem_loader.sv
// Loads a framed byte stream (length, payload, XOR checksum) into the code
// memory write port from address 0, holding the CPU off while it does so.
module code_mem_loader
  import code_mem_loader_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_t             state_r;
  state_t             state_nx_s;
  logic               in_ready_r;
  logic               cpu_hold_r;
  logic               done_r;
  logic               err_r;
  logic               wr_en_r;
  logic [ADDR_W-1:0]  wr_addr_r;
  logic [7:0]         wr_data_r;
  logic [7:0]         len_hi_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   cnt_r;
  logic [7:0]         acc_r;

  logic               xfer_s;
  logic               clr_s;
  logic               data_wr_s;
  logic [LEN_W-1:0]   n_s;
  logic [LEN_W-1:0]   cnt_inc_s;

  // Next-state decode plus the per-cycle clear and payload-write strobes.
  always_comb begin
    state_nx_s = state_r;
    clr_s      = 1'b0;
    data_wr_s  = 1'b0;
    xfer_s     = in_valid && in_ready_r;
    n_s        = {len_hi_r, in_data};
    cnt_inc_s  = cnt_r + 16'd1;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_nx_s = LEN_HI;
          clr_s      = 1'b1;
        end else begin
          state_nx_s = state_r;
        end
      end
      LEN_HI: begin
        if (xfer_s) state_nx_s = LEN_LO;
        else        state_nx_s = state_r;
      end
      LEN_LO: begin
        if (!xfer_s)              state_nx_s = state_r;
        else if (n_s > DEPTH_L)   state_nx_s = ERR;
        else if (n_s == 16'd0)    state_nx_s = CSUM;
        else                      state_nx_s = DATA;
      end
      DATA: begin
        if (xfer_s) begin
          data_wr_s = 1'b1;
          if (cnt_inc_s == len_r) state_nx_s = CSUM;
          else                    state_nx_s = state_r;
        end else begin
          state_nx_s = state_r;
        end
      end
      CSUM: begin
        if (!xfer_s)              state_nx_s = state_r;
        else if (in_data == acc_r) state_nx_s = DONE;
        else                      state_nx_s = ERR;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register and status flags; flags are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      cpu_hold_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= frame_active(state_nx_s);
      cpu_hold_r <= frame_active(state_nx_s);
      done_r     <= (state_nx_s == DONE);
      err_r      <= (state_nx_s == ERR);
    end
  end

  // Length capture, byte counter and checksum accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_hi_r <= 8'h00;
      len_r    <= 16'd0;
      cnt_r    <= 16'd0;
      acc_r    <= 8'h00;
    end else begin
      if (state_r == LEN_HI && xfer_s) len_hi_r <= in_data;
      if (state_r == LEN_LO && xfer_s) len_r    <= n_s;
      if (clr_s) begin
        cnt_r <= 16'd0;
        acc_r <= 8'h00;
      end else if (data_wr_s) begin
        cnt_r <= cnt_inc_s;
        acc_r <= csum_step(acc_r, in_data);
      end
    end
  end

  // Registered write port: a byte accepted this cycle is written next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= 8'h00;
    end else begin
      wr_en_r <= data_wr_s;
      if (data_wr_s) begin
        wr_addr_r <= ADDR_W'(cnt_r);
        wr_data_r <= in_data;
      end
    end
  end

  assign in_ready = in_ready_r;
  assign cpu_hold = cpu_hold_r;
  assign done     = done_r;
  assign err      = err_r;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;

endmodule

// File: tb/tb_code_mem_loader.sv
// Directed bench for code_mem_loader: a table of frames plus hand-written
// reset, stall and restart sequences, with a byte-array memory model.
module tb_code_mem_loader;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  code_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Code memory model plus a log of every write strobe in the current frame.
  logic [7:0]  mem      [0:DEPTH-1];
  logic [31:0] log_addr [0:255];
  logic [7:0]  log_data [0:255];
  int          wr_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= 0;
    end else if (start && !cpu_hold) begin
      wr_cnt <= 0;
    end else if (wr_en) begin
      log_addr[wr_cnt[7:0]] <= wr_addr;
      log_data[wr_cnt[7:0]] <= wr_data;
      wr_cnt <= wr_cnt + 1;
      if (wr_addr < DEPTH) mem[wr_addr[6:0]] <= wr_data;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] pay [0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic with_valid, input logic [7:0] b);
    start    = 1'b1;
    in_valid = with_valid;
    in_data  = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] len;
    logic [31:0] pay4;
    logic [7:0]  csum;
    bit          body;
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
    bit          do_fetch;
    logic [31:0] exp_fetch;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;
    logic [7:0] b;
    int bad;

    vecs[0] = '{16'd4,      32'h11223344, 8'h44, 1'b1, 1'b1, 1'b0, 4, 1'b1, 32'h11223344};
    vecs[1] = '{16'd4,      32'h11223344, 8'h45, 1'b1, 1'b0, 1'b1, 4, 1'b1, 32'h11223344};
    vecs[2] = '{16'h0081,   32'h0,        8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h0};
    vecs[3] = '{16'd0,      32'h0,        8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'h0};
    vecs[4] = '{16'd0,      32'h0,        8'h01, 1'b1, 1'b0, 1'b1, 0, 1'b0, 32'h0};
    vecs[5] = '{16'd2,      32'hA55A0000, 8'hFF, 1'b1, 1'b1, 1'b0, 2, 1'b1, 32'hA55A3344};
    vecs[6] = '{16'h0100,   32'h0,        8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h0};
    vecs[7] = '{16'd1,      32'h80000000, 8'h80, 1'b1, 1'b1, 1'b0, 1, 1'b1, 32'h805A3344};

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en",    32'(wr_en),    32'd0);
    check("rst_wr_addr",  wr_addr,       32'd0);
    check("rst_wr_data",  32'(wr_data),  32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_err",      32'(err),      32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Table of frames.
    for (int v = 0; v < 8; v++) begin
      pulse_start(1'b0, 8'h00);
      check("start_hold", 32'(cpu_hold), 32'd1);
      check("start_done_clr", 32'({done, err}), 32'd0);
      send_byte(vecs[v].len[15:8]);
      send_byte(vecs[v].len[7:0]);
      if (vecs[v].body) begin
        for (int k = 0; k < int'(vecs[v].len); k++) begin
          b = vecs[v].pay4[31 - 8*k -: 8];
          pay[k] = b;
          send_byte(b);
        end
        send_byte(vecs[v].csum);
      end
      check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_err", v),  32'(err),  32'(vecs[v].exp_err));
      check($sformatf("v%0d_hold", v), 32'(cpu_hold), 32'd0);
      check($sformatf("v%0d_ready", v), 32'(in_ready), 32'd0);
      check($sformatf("v%0d_wrcnt", v), 32'(wr_cnt), 32'(vecs[v].exp_wr));
      for (int k = 0; k < vecs[v].exp_wr; k++) begin
        check($sformatf("v%0d_addr%0d", v, k), log_addr[k], 32'(k));
        check($sformatf("v%0d_data%0d", v, k), 32'(log_data[k]), 32'(pay[k]));
      end
      if (vecs[v].do_fetch)
        check($sformatf("v%0d_fetch", v), {mem[0], mem[1], mem[2], mem[3]}, vecs[v].exp_fetch);
    end

    // Reset in the middle of an 8-byte frame, then reload it.
    pulse_start(1'b0, 8'h00);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    rst = 1'b0;
    #1;
    check("mid_rst_outs", {25'd0, in_ready, wr_en, cpu_hold, done, err, |wr_addr, |wr_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_start(1'b0, 8'h00);
    send_byte(8'h00);
    send_byte(8'h08);
    for (int k = 0; k < 8; k++) send_byte(8'(k + 1));
    send_byte(8'h08);
    check("rl_done", 32'({done, err}), 32'h2);
    check("rl_wrcnt", 32'(wr_cnt), 32'd8);
    check("rl_fetch0", {mem[0], mem[1], mem[2], mem[3]}, 32'h01020304);
    check("rl_fetch4", {mem[4], mem[5], mem[6], mem[7]}, 32'h05060708);

    // start and in_valid together from DONE: the byte must not be taken.
    pulse_start(1'b1, 8'hFF);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h5C);
    send_byte(8'h5C);
    check("sv_done", 32'({done, err}), 32'h2);
    check("sv_mem0", 32'(mem[0]), 32'h5C);

    // Full-depth frame with random stalls and an ignored mid-frame start.
    pulse_start(1'b0, 8'h00);
    send_byte(8'h00);
    send_byte(8'h80);
    cs = 8'h00;
    for (int i = 0; i < 128; i++) begin
      if (i == 50) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_hold", 32'({cpu_hold, in_ready, done, err}), 32'hC);
      end else if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      b = 8'(i * 3 + 7);
      pay[i] = b;
      cs = cs ^ b;
      send_byte(b);
    end
    send_byte(cs);
    check("big_done", 32'({done, err, cpu_hold}), 32'h4);
    check("big_wrcnt", 32'(wr_cnt), 32'd128);
    check("big_last_addr", log_addr[127], 32'd127);
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (log_addr[i] !== 32'(i) || log_data[i] !== pay[i] || mem[i] !== pay[i]) bad++;
    check("big_contents", 32'(bad), 32'd0);

    // Second start after DONE clears status and reloads.
    pulse_start(1'b0, 8'h00);
    check("re_clear", 32'({done, err, cpu_hold, in_ready}), 32'h3);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h22);
    check("re_done", 32'({done, err}), 32'h2);
    check("re_fetch", {mem[0], mem[1], mem[2], mem[3]}, 32'hDEADBEEF);
    check("re_keep", 32'(mem[4]), 32'(8'(4 * 3 + 7)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
